// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM request-port arbiter.
// Holds the FSM state encoding and helpers for slicing the packed per-port buses.
package sdram_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_CAPTURE,
    ST_DONE
  } arb_state_t;

  localparam int DEF_AW = 24;
  localparam int DEF_DW = 16;
  localparam int DS_W   = 2;

  // Low bit of port idx's field within a packed per-port bus of the given field width.
  function automatic int slice_lo(input logic [1:0] idx, input int width);
    return int'(idx) * width;
  endfunction

endpackage

// File: rtl/sdram_arbiter_rr_pick.sv
// Combinational round-robin picker with optional absolute priority for port 0.
// The search starts at the port after the last grant and wraps modulo NPORTS.
module rr_pick #(
  parameter int NPORTS = 3,
  parameter bit PRIO0  = 1'b0
) (
  input  logic [NPORTS-1:0] i_eligible,
  input  logic [1:0]        i_last_grant,
  output logic [1:0]        o_winner,
  output logic              o_valid
);

  logic [1:0] w_cand;

  always_comb begin
    o_winner = 2'd0;
    o_valid  = 1'b0;
    w_cand   = 2'd0;
    if (PRIO0 && i_eligible[0]) begin
      o_valid = 1'b1;
    end else begin
      for (int k = 1; k <= NPORTS; k++) begin
        w_cand = 2'((int'(i_last_grant) + k) % NPORTS);
        if (!o_valid && i_eligible[w_cand]) begin
          o_valid  = 1'b1;
          o_winner = w_cand;
        end
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Shares the single SDRAM controller request port among NPORTS requesters.
// One access per controller slot; read data is returned on a shared bus with a per-port ack.
//
// state   | meaning
// IDLE    | waiting for slot_en with an eligible port
// ISSUE   | mem_req high for one cycle, command registers valid
// WAIT    | counting down until the controller's read data is valid
// CAPTURE | latch mem_dout (reads only)
// DONE    | port_ack of the granted port high for one cycle
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NPORTS     = 3,
  parameter int AW         = DEF_AW,
  parameter int DW         = DEF_DW,
  parameter int RD_LATENCY = 6,
  parameter bit PRIO0      = 1'b0
) (
  input  logic                 clk_sdram,
  input  logic                 reset,
  input  logic                 slot_en,
  input  logic [NPORTS-1:0]    port_req,
  input  logic [NPORTS-1:0]    port_we,
  input  logic [NPORTS*AW-1:0] port_addr,
  input  logic [NPORTS*DW-1:0] port_din,
  input  logic [NPORTS*2-1:0]  port_ds,
  output logic [NPORTS-1:0]    port_ack,
  output logic [DW-1:0]        port_dout,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_din,
  output logic [1:0]           mem_ds,
  input  logic [DW-1:0]        mem_dout,
  output logic                 busy,
  output logic [1:0]           grant_idx
);

  localparam int CW        = (RD_LATENCY > 2) ? $clog2(RD_LATENCY) : 1;
  localparam int WAIT_LOAD = (RD_LATENCY >= 2) ? RD_LATENCY - 2 : 0;

  arb_state_t        r_state;
  logic [CW-1:0]     r_cnt;
  logic [NPORTS-1:0] r_mask;
  logic [NPORTS-1:0] r_port_ack;
  logic [1:0]        r_grant;
  logic [1:0]        r_last_grant;
  logic              r_busy;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [AW-1:0]     r_mem_addr;
  logic [DW-1:0]     r_mem_din;
  logic [1:0]        r_mem_ds;
  logic [DW-1:0]     r_port_dout;

  logic [NPORTS-1:0] w_eligible;
  logic [1:0]        w_pick;
  logic              w_pick_valid;

  // A just-acked port stays masked for one cycle so a requester that has not yet dropped req is not re-granted.
  assign w_eligible = port_req & ~r_mask;

  rr_pick #(
    .NPORTS (NPORTS),
    .PRIO0  (PRIO0)
  ) u_rr_pick (
    .i_eligible   (w_eligible),
    .i_last_grant (r_last_grant),
    .o_winner     (w_pick),
    .o_valid      (w_pick_valid)
  );

  always_ff @(posedge clk_sdram or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_mask       <= '0;
      r_port_ack   <= '0;
      r_grant      <= 2'd0;
      r_last_grant <= 2'(NPORTS - 1);
      r_busy       <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_din    <= '0;
      r_mem_ds     <= 2'b00;
      r_port_dout  <= '0;
    end else begin
      r_mem_req  <= 1'b0;
      r_port_ack <= '0;
      r_mask     <= '0;
      case (r_state)
        ST_IDLE: begin
          if (slot_en && w_pick_valid) begin
            r_state      <= ST_ISSUE;
            r_mem_req    <= 1'b1;
            r_busy       <= 1'b1;
            r_grant      <= w_pick;
            r_last_grant <= w_pick;
            r_mem_we     <= port_we[w_pick];
            r_mem_addr   <= port_addr[slice_lo(w_pick, AW) +: AW];
            r_mem_din    <= port_din[slice_lo(w_pick, DW) +: DW];
            r_mem_ds     <= port_ds[slice_lo(w_pick, DS_W) +: DS_W];
          end
        end
        ST_ISSUE: begin
          if (RD_LATENCY == 1) begin
            r_state <= ST_CAPTURE;
          end else begin
            r_state <= ST_WAIT;
            r_cnt   <= CW'(WAIT_LOAD);
          end
        end
        ST_WAIT: begin
          if (r_cnt == '0) begin
            r_state <= ST_CAPTURE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        ST_CAPTURE: begin
          if (!r_mem_we) begin
            r_port_dout <= mem_dout;
          end
          r_port_ack[r_grant] <= 1'b1;
          r_state             <= ST_DONE;
        end
        ST_DONE: begin
          r_mask[r_grant] <= 1'b1;
          r_busy          <= 1'b0;
          r_state         <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign port_ack  = r_port_ack;
  assign port_dout = r_port_dout;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_din   = r_mem_din;
  assign mem_ds    = r_mem_ds;
  assign busy      = r_busy;
  assign grant_idx = r_grant;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: a PRIO0=0 instance with a controller model, plus a PRIO0=1 twin sharing the requests.
module tb_sdram_arbiter;

  localparam int NP = 3;
  localparam int AW = 24;
  localparam int DW = 16;
  localparam int RL = 6;

  logic              clk_sdram = 1'b0;
  logic              reset;
  logic              slot_en;
  logic [NP-1:0]     port_req;
  logic [NP-1:0]     port_we;
  logic [NP*AW-1:0]  port_addr;
  logic [NP*DW-1:0]  port_din;
  logic [NP*2-1:0]   port_ds;
  logic [DW-1:0]     mem_dout;

  logic [NP-1:0]     port_ack,   p_port_ack;
  logic [DW-1:0]     port_dout,  p_port_dout;
  logic              mem_req,    p_mem_req;
  logic              mem_we,     p_mem_we;
  logic [AW-1:0]     mem_addr,   p_mem_addr;
  logic [DW-1:0]     mem_din,    p_mem_din;
  logic [1:0]        mem_ds,     p_mem_ds;
  logic              busy,       p_busy;
  logic [1:0]        grant_idx,  p_grant_idx;

  logic [15:0] model_mem [0:255];
  logic [15:0] pipe_d [0:RL];
  bit          slot_auto;
  int          slot_period;
  int          slot_ph;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk_sdram = ~clk_sdram;

  sdram_arbiter #(.NPORTS(NP), .AW(AW), .DW(DW), .RD_LATENCY(RL), .PRIO0(1'b0)) dut (
    .clk_sdram(clk_sdram), .reset(reset), .slot_en(slot_en),
    .port_req(port_req), .port_we(port_we), .port_addr(port_addr), .port_din(port_din), .port_ds(port_ds),
    .port_ack(port_ack), .port_dout(port_dout),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_ds(mem_ds),
    .mem_dout(mem_dout), .busy(busy), .grant_idx(grant_idx)
  );

  sdram_arbiter #(.NPORTS(NP), .AW(AW), .DW(DW), .RD_LATENCY(RL), .PRIO0(1'b1)) dut_p (
    .clk_sdram(clk_sdram), .reset(reset), .slot_en(slot_en),
    .port_req(port_req), .port_we(port_we), .port_addr(port_addr), .port_din(port_din), .port_ds(port_ds),
    .port_ack(p_port_ack), .port_dout(p_port_dout),
    .mem_req(p_mem_req), .mem_we(p_mem_we), .mem_addr(p_mem_addr), .mem_din(p_mem_din), .mem_ds(p_mem_ds),
    .mem_dout(16'h0000), .busy(p_busy), .grant_idx(p_grant_idx)
  );

  // Advance one cycle; inputs and the controller model update 1 ns after the edge.
  task automatic step();
    @(posedge clk_sdram);
    #1;
    for (int k = RL; k > 0; k--) pipe_d[k] = pipe_d[k-1];
    pipe_d[0] = 16'hDEAD;
    if (mem_req) begin
      if (mem_we) begin
        if (mem_ds[1]) model_mem[mem_addr[7:0]][15:8] = mem_din[15:8];
        if (mem_ds[0]) model_mem[mem_addr[7:0]][7:0]  = mem_din[7:0];
      end else begin
        pipe_d[0] = model_mem[mem_addr[7:0]];
      end
    end
    mem_dout = pipe_d[RL];
    if (slot_auto) begin
      slot_en = (slot_ph == 0);
      slot_ph = (slot_ph + 1) % slot_period;
    end
  endtask

  task automatic set_port(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] ds);
    port_we[i]          = we;
    port_addr[i*AW +: AW] = a;
    port_din[i*DW +: DW]  = d;
    port_ds[i*2 +: 2]     = ds;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    slot_auto = 1'b0;
    slot_en   = 1'b0;
    port_req  = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    n_vec++; if (mem_req !== 1'b0)   begin n_err++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    n_vec++; if (busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (port_ack !== 3'b000) begin n_err++; $display("FAIL reset_port_ack: got %b want 000", port_ack); end
    n_vec++; if (grant_idx !== 2'd0) begin n_err++; $display("FAIL reset_grant_idx: got %0d want 0", grant_idx); end
    n_vec++; if ({mem_we, mem_addr, mem_din, mem_ds, port_dout} !== '0) begin n_err++; $display("FAIL reset_regs: got we=%b addr=%h din=%h ds=%b dout=%h want all 0", mem_we, mem_addr, mem_din, mem_ds, port_dout); end
    n_vec++; if ({p_mem_req, p_busy, p_port_ack, p_grant_idx, p_mem_we, p_mem_addr, p_mem_din, p_mem_ds, p_port_dout} !== '0) begin n_err++; $display("FAIL reset_prio_dut: got nonzero outputs, want all 0"); end
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    do_reset();
    model_mem[8'h23] = 16'hBEEF;
    set_port(1, 1'b0, 24'h000123, 16'h0000, 2'b11);
    port_req = 3'b010;
    slot_en  = 1'b1;
    step();
    slot_en = 1'b0;
    n_vec++; if (mem_req !== 1'b1)        begin n_err++; $display("FAIL rd_mem_req: got %b want 1", mem_req); end
    n_vec++; if (mem_addr !== 24'h000123) begin n_err++; $display("FAIL rd_mem_addr: got %h want 000123", mem_addr); end
    n_vec++; if (mem_we !== 1'b0)         begin n_err++; $display("FAIL rd_mem_we: got %b want 0", mem_we); end
    n_vec++; if (busy !== 1'b1)           begin n_err++; $display("FAIL rd_busy: got %b want 1", busy); end
    n_vec++; if (grant_idx !== 2'd1)      begin n_err++; $display("FAIL rd_grant: got %0d want 1", grant_idx); end
    repeat (6) step();
    n_vec++; if (port_ack !== 3'b000)     begin n_err++; $display("FAIL rd_early_ack: got %b want 000", port_ack); end
    step();
    n_vec++; if (port_ack !== 3'b010)     begin n_err++; $display("FAIL rd_ack: got %b want 010", port_ack); end
    n_vec++; if (port_dout !== 16'hBEEF)  begin n_err++; $display("FAIL rd_dout: got %h want beef", port_dout); end
    n_vec++; if (busy !== 1'b1)           begin n_err++; $display("FAIL rd_busy_at_ack: got %b want 1", busy); end
    port_req = 3'b000;
    step();
    n_vec++; if ({busy, port_ack} !== 4'b0000) begin n_err++; $display("FAIL rd_after: got busy=%b ack=%b want 0/000", busy, port_ack); end
  endtask

  task automatic test_write_read();
    model_mem[8'h40] = 16'h1234;
    set_port(2, 1'b1, 24'h000040, 16'h5A5A, 2'b01);
    port_req = 3'b100;
    slot_en  = 1'b1;
    step();
    slot_en = 1'b0;
    n_vec++; if ({mem_req, mem_we} !== 2'b11) begin n_err++; $display("FAIL wr_cmd: got req=%b we=%b want 1/1", mem_req, mem_we); end
    n_vec++; if (mem_din !== 16'h5A5A)        begin n_err++; $display("FAIL wr_din: got %h want 5a5a", mem_din); end
    n_vec++; if (mem_ds !== 2'b01)            begin n_err++; $display("FAIL wr_ds: got %b want 01", mem_ds); end
    n_vec++; if (mem_addr !== 24'h000040)     begin n_err++; $display("FAIL wr_addr: got %h want 000040", mem_addr); end
    n_vec++; if (grant_idx !== 2'd2)          begin n_err++; $display("FAIL wr_grant: got %0d want 2", grant_idx); end
    repeat (7) step();
    n_vec++; if (port_ack !== 3'b100)         begin n_err++; $display("FAIL wr_ack: got %b want 100", port_ack); end
    n_vec++; if (port_dout !== 16'hBEEF)      begin n_err++; $display("FAIL wr_dout_held: got %h want beef", port_dout); end
    port_req = 3'b000;
    step();
    step();
    set_port(2, 1'b0, 24'h000040, 16'h0000, 2'b11);
    port_req = 3'b100;
    slot_en  = 1'b1;
    step();
    slot_en = 1'b0;
    n_vec++; if ({mem_req, mem_we} !== 2'b10) begin n_err++; $display("FAIL rb_cmd: got req=%b we=%b want 1/0", mem_req, mem_we); end
    repeat (7) step();
    n_vec++; if (port_ack !== 3'b100)         begin n_err++; $display("FAIL rb_ack: got %b want 100", port_ack); end
    n_vec++; if (port_dout !== 16'h125A)      begin n_err++; $display("FAIL rb_dout: got %h want 125a", port_dout); end
    port_req = 3'b000;
    step();
  endtask

  task automatic test_stale();
    do_reset();
    set_port(0, 1'b0, 24'h000050, 16'h0000, 2'b11);
    set_port(1, 1'b0, 24'h000051, 16'h0000, 2'b11);
    port_req = 3'b011;
    slot_en  = 1'b1;
    step();
    slot_en = 1'b0;
    n_vec++; if ({mem_req, grant_idx} !== 3'b100) begin n_err++; $display("FAIL stale_first: got req=%b grant=%0d want 1/0", mem_req, grant_idx); end
    repeat (7) step();
    n_vec++; if (port_ack !== 3'b001) begin n_err++; $display("FAIL stale_ack0: got %b want 001", port_ack); end
    step();
    slot_en = 1'b1;
    step();
    slot_en  = 1'b0;
    port_req = 3'b010;
    n_vec++; if ({mem_req, grant_idx} !== 3'b101)     begin n_err++; $display("FAIL stale_rr: got req=%b grant=%0d want 1/1", mem_req, grant_idx); end
    n_vec++; if ({p_mem_req, p_grant_idx} !== 3'b101) begin n_err++; $display("FAIL stale_prio: got req=%b grant=%0d want 1/1", p_mem_req, p_grant_idx); end
    n_vec++; if (mem_addr !== 24'h000051)            begin n_err++; $display("FAIL stale_addr: got %h want 000051", mem_addr); end
    repeat (7) step();
    n_vec++; if (port_ack !== 3'b010) begin n_err++; $display("FAIL stale_ack1: got %b want 010", port_ack); end
    port_req = 3'b000;
    step();
  endtask

  task automatic test_round_robin();
    int k;
    int acks;
    int prev;
    logic [2:0] exp_ack;
    do_reset();
    for (int i = 0; i < NP; i++) set_port(i, 1'b0, 24'h000010 + AW'(i), 16'h0000, 2'b11);
    port_req    = 3'b111;
    slot_period = 9;
    slot_ph     = 0;
    slot_auto   = 1'b1;
    k = 0; acks = 0; prev = -1;
    for (int c = 0; c < 80 && k < 6; c++) begin
      step();
      if (port_ack !== 3'b000) begin
        acks++;
        exp_ack = (prev < 0) ? 3'b000 : 3'(1 << prev);
        n_vec++; if (port_ack !== exp_ack) begin n_err++; $display("FAIL rr_ack: got %b want %b", port_ack, exp_ack); end
      end
      if (mem_req === 1'b1) begin
        n_vec++; if (grant_idx !== 2'(k % 3)) begin n_err++; $display("FAIL rr_order: grant %0d got %0d want %0d", k, grant_idx, k % 3); end
        n_vec++; if (mem_addr !== 24'h000010 + AW'(k % 3)) begin n_err++; $display("FAIL rr_addr: got %h want %h", mem_addr, 24'h000010 + AW'(k % 3)); end
        if (k > 0) begin
          n_vec++; if (acks != 1) begin n_err++; $display("FAIL rr_ack_before_req: got %0d acks want 1", acks); end
        end
        acks = 0;
        prev = k % 3;
        k++;
      end
    end
    n_vec++; if (k != 6) begin n_err++; $display("FAIL rr_timeout: got %0d grants want 6", k); end
    slot_auto = 1'b0;
    slot_en   = 1'b0;
    port_req  = 3'b000;
  endtask

  task automatic test_prio0();
    int k;
    int exp_a [4];
    int exp_b [3];
    exp_a = '{0, 2, 0, 2};
    exp_b = '{0, 0, 0};
    do_reset();
    for (int i = 0; i < NP; i++) set_port(i, 1'b0, 24'h000060 + AW'(i), 16'h0000, 2'b11);
    port_req    = 3'b101;
    slot_period = 9;
    slot_ph     = 0;
    slot_auto   = 1'b1;
    k = 0;
    for (int c = 0; c < 60 && k < 4; c++) begin
      step();
      if (p_mem_req === 1'b1) begin
        n_vec++; if (p_grant_idx !== 2'(exp_a[k])) begin n_err++; $display("FAIL prio_masked: grant %0d got %0d want %0d", k, p_grant_idx, exp_a[k]); end
        k++;
      end
    end
    n_vec++; if (k != 4) begin n_err++; $display("FAIL prio_masked_timeout: got %0d grants want 4", k); end
    do_reset();
    port_req    = 3'b101;
    slot_period = 13;
    slot_ph     = 0;
    slot_auto   = 1'b1;
    k = 0;
    for (int c = 0; c < 60 && k < 3; c++) begin
      step();
      if (p_mem_req === 1'b1) begin
        n_vec++; if (p_grant_idx !== 2'(exp_b[k])) begin n_err++; $display("FAIL prio_wins: grant %0d got %0d want %0d", k, p_grant_idx, exp_b[k]); end
        k++;
      end
    end
    n_vec++; if (k != 3) begin n_err++; $display("FAIL prio_wins_timeout: got %0d grants want 3", k); end
    slot_auto = 1'b0;
    slot_en   = 1'b0;
    port_req  = 3'b000;
  endtask

  task automatic test_reset_mid_access();
    int acks;
    do_reset();
    set_port(0, 1'b0, 24'h000070, 16'h0000, 2'b11);
    set_port(1, 1'b0, 24'h000071, 16'h0000, 2'b11);
    port_req = 3'b010;
    slot_en  = 1'b1;
    step();
    slot_en = 1'b0;
    n_vec++; if ({mem_req, grant_idx} !== 3'b101) begin n_err++; $display("FAIL mid_grant: got req=%b grant=%0d want 1/1", mem_req, grant_idx); end
    repeat (3) step();
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy_before: got %b want 1", busy); end
    #3;
    reset = 1'b1;
    #1;
    n_vec++; if ({mem_req, busy, port_ack} !== 5'b00000) begin n_err++; $display("FAIL mid_async: got req=%b busy=%b ack=%b want 0/0/000", mem_req, busy, port_ack); end
    n_vec++; if ({grant_idx, mem_addr} !== '0) begin n_err++; $display("FAIL mid_async_regs: got grant=%0d addr=%h want 0/0", grant_idx, mem_addr); end
    step();
    step();
    reset = 1'b0;
    acks = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (port_ack !== 3'b000 || mem_req !== 1'b0) acks++;
    end
    n_vec++; if (acks != 0) begin n_err++; $display("FAIL mid_no_ack: got %0d active cycles want 0", acks); end
    port_req = 3'b011;
    slot_en  = 1'b1;
    step();
    slot_en = 1'b0;
    n_vec++; if ({mem_req, grant_idx} !== 3'b100) begin n_err++; $display("FAIL mid_first_grant: got req=%b grant=%0d want 1/0", mem_req, grant_idx); end
    port_req = 3'b000;
  endtask

  initial begin
    reset       = 1'b1;
    slot_en     = 1'b0;
    slot_auto   = 1'b0;
    slot_period = 9;
    slot_ph     = 0;
    port_req    = '0;
    port_we     = '0;
    port_addr   = '0;
    port_din    = '0;
    port_ds     = '0;
    mem_dout    = 16'h0000;
    for (int i = 0; i < 256; i++) model_mem[i] = 16'h0000;
    for (int i = 0; i <= RL; i++) pipe_d[i] = 16'hDEAD;
    test_reset();
    test_single_read();
    test_write_read();
    test_stale();
    test_round_robin();
    test_prio0();
    test_reset_mid_access();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
